binary_to_bcd: RTL and testbench
================================

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 SHALL have parameter DATA_W, default 20: binary input width.
REQ-002 SHALL have parameter DIGITS, default 6: BCD output digits, one per HEX display.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: bin_in is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a new value.
REQ-007 SHALL have port bin_in, input, DATA_W: unsigned value to convert.
REQ-008 SHALL have port out_valid, output, 1: one-cycle pulse when new digits are published.
REQ-009 SHALL have port digits, output, DIGITS x 4: BCD digits, index 0 is least significant, held between conversions.
REQ-010 SHALL have port digit_en, output, DIGITS: per-digit display enable mask.
REQ-011 SHALL have port overflow, output, 1: last converted value exceeded 10^DIGITS-1, held with digits.

Function
REQ-012 SHALL implement an iterative double-dabble FSM with states IDLE and SHIFT.
REQ-013 IDLE SHALL drive in_ready=1; SHIFT SHALL drive in_ready=0.
REQ-014 in_valid&&in_ready at an edge SHALL load bin_in into the shift register, clear the DIGITS+1-digit scratch BCD register, zero the bit counter, and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL add 3 to every scratch digit >=5, then shift {scratch,shift} left by one bit.
REQ-016 The edge performing shift number DATA_W SHALL update digits, overflow and digit_en, assert out_valid for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be DATA_W cycles from the accept edge to out_valid high; throughput SHALL be one conversion per DATA_W+1 cycles.
REQ-018 in_valid during SHIFT SHALL be ignored; no input value SHALL be buffered.
REQ-019 overflow SHALL equal (scratch digit DIGITS != 0); digits SHALL be the lower DIGITS digits, i.e. value mod 10^DIGITS.
REQ-020 An accept in the IDLE cycle immediately following out_valid SHALL be legal (back-to-back operation).
REQ-021 digits, overflow and digit_en SHALL change only at the publishing edge.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, in_ready=1 after release, out_valid=0, digits all 0, overflow=0, digit_en all 1, and clear the scratch, shift and counter registers.
REQ-023 Reset mid-conversion SHALL abort the conversion without publishing; outputs SHALL show the reset values.

Configuration
REQ-024 Macro BIN2BCD_BLANK_EN defined: digit_en SHALL clear every leading-zero digit above the most significant nonzero digit; digit 0 SHALL always be enabled.
REQ-025 Macro BIN2BCD_BLANK_EN undefined: digit_en SHALL be constant all ones.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold DATA_W_DEF=20, DIGITS_DEF=6, typedef bcd_digit_t (4-bit), and the FSM state enum.
REQ-027 Sub-module bcd_add3 SHALL implement the combinational per-digit >=5 add-3 correction, instantiated DIGITS+1 times.

Verification
REQ-028 bin_in=0 -> after 20 cycles out_valid pulse, digits=000000, overflow=0, digit_en=111111 (000001 with BIN2BCD_BLANK_EN).
REQ-029 bin_in=123456 then bin_in=999999 back-to-back -> digits=123456, then 999999; both with overflow=0; exactly 21 cycles between accepts.
REQ-030 bin_in=1048575 -> digits=048575, overflow=1; bin_in=1000000 -> digits=000000, overflow=1.
REQ-031 bin_in=42 with BIN2BCD_BLANK_EN -> digits=000042, digit_en=000011.
REQ-032 Assert rst_n low at shift 10 of a 777777 conversion -> no out_valid pulse, digits=000000, in_ready=1 after release.
REQ-033 Toggle in_valid with a different bin_in during SHIFT -> ignored; the published result matches the originally accepted value.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   DATA_W_DEF  : default binary input width
//   DIGITS_DEF  : default number of published BCD digits
//   BCD_W       : width of one BCD digit
//   bcd_digit_t : one BCD digit
//   state_t     : converter FSM state encoding
package bin2bcd_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int DIGITS_DEF = 6;
    localparam int BCD_W      = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_in  : scratch BCD digit before correction
//   digit_out : corrected digit (digit_in + 3 when digit_in >= 5)
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    bcd_digit_t sum;

    always_comb begin
        sum       = digit_in + 4'd3;
        digit_out = (digit_in >= 4'd5) ? sum : digit_in;
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Iterative double-dabble binary to BCD converter for a multi-digit display.
// One bit is shifted per cycle; a conversion takes DATA_W cycles after accept
// and the result is held on the outputs until the next publish.
//
// Optional build macro:
//   BIN2BCD_BLANK_EN - digit_en blanks leading-zero digits (digit 0 always on);
//                      undefined, digit_en is constant all ones.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : bin_in is valid
//   in_ready  : converter idle and accepting a value
//   bin_in    : unsigned binary value to convert
//   out_valid : one-cycle pulse when new digits are published
//   digits    : BCD digits, digit 0 in bits [3:0]
//   digit_en  : per-digit display enable
//   overflow  : last converted value exceeded 10^DIGITS-1
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for in_valid, in_ready high
// ST_SHIFT | one add-3/shift step per cycle, publishes on the last step
module binary_to_bcd
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  out_valid,
    output logic [DIGITS*4-1:0]   digits,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow
);

    // One extra scratch digit catches values above 10^DIGITS-1.
    localparam int SCR_W = (DIGITS + 1) * BCD_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS*4-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                overflow_q, overflow_d;
    logic                out_valid_q, out_valid_d;

    logic [SCR_W-1:0]    scratch_fix;
    logic [SCR_W-1:0]    scratch_sh;
    logic [DATA_W-1:0]   shift_sh;
    logic [DIGITS-1:0]   en_new;

    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*BCD_W +: BCD_W]),
            .digit_out (scratch_fix[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        scratch_sh = {scratch_fix[SCR_W-2:0], shift_q[DATA_W-1]};
        shift_sh   = {shift_q[DATA_W-2:0], 1'b0};
    end

`ifdef BIN2BCD_BLANK_EN
    // Enable runs from the most significant nonzero displayed digit downward.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        en_new = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (scratch_sh[i*BCD_W +: BCD_W] != '0) begin
                seen = 1'b1;
            end
            en_new[i] = seen;
        end
        en_new[0] = 1'b1;
    end
`else
    always_comb begin
        en_new = '1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        digit_en_d  = digit_en_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = shift_sh;
                scratch_d = scratch_sh;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    digits_d    = scratch_sh[DIGITS*BCD_W-1:0];
                    overflow_d  = (scratch_sh[SCR_W-1 -: BCD_W] != '0);
                    digit_en_d  = en_new;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            digit_en_q  <= '1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            digit_en_q  <= digit_en_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign digits    = digits_q;
    assign digit_en  = digit_en_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed bench for binary_to_bcd (DATA_W=20, DIGITS=6).
// Expected digit_en depends on whether BIN2BCD_BLANK_EN is defined.
module tb_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] bin_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] digits;
    logic [5:0]  digit_en;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int prev_accept_cyc = 0;
    logic [23:0] prev_digits = '0;
    logic        prev_ovf = 1'b0;

    binary_to_bcd #(.DATA_W(20), .DIGITS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .digits    (digits),
        .digit_en  (digit_en),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept v, optionally poke a different value during SHIFT, wait for the
    // publish pulse and compare against hand-computed results.
    task automatic convert(input logic [19:0] v, input logic [23:0] exp_d,
                           input logic exp_o, input logic [5:0] exp_blank,
                           input bit poke);
        int lat;
        logic [5:0] exp_en;
`ifdef BIN2BCD_BLANK_EN
        exp_en = exp_blank;
`else
        exp_en = 6'h3f;
`endif
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        bin_in   = '0;
        check("out_valid_low_after_accept", out_valid, 1'b0);
        check("in_ready_busy", in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 10) begin
                check("digits_held", digits, prev_digits);
                check("overflow_held", overflow, prev_ovf);
            end
            if (poke && lat == 5) begin
                check("in_ready_poke", in_ready, 1'b0);
                in_valid = 1'b1;
                bin_in   = 20'd271828;
            end
            if (poke && lat == 8) begin
                in_valid = 1'b0;
                bin_in   = '0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 20);
        check("digits", digits, exp_d);
        check("overflow", overflow, exp_o);
        check("digit_en", digit_en, exp_en);
        check("in_ready_on_publish", in_ready, 1'b1);
        prev_digits = exp_d;
        prev_ovf    = exp_o;
    endtask

    initial begin
        bit seen;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_digits", digits, 24'h000000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_digit_en", digit_en, 6'h3f);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        convert(20'd0, 24'h000000, 1'b0, 6'b000001, 1'b0);

        // back-to-back: second accept in the IDLE cycle carrying out_valid
        convert(20'd123456, 24'h123456, 1'b0, 6'b111111, 1'b0);
        prev_accept_cyc = accept_cyc;
        convert(20'd999999, 24'h999999, 1'b0, 6'b111111, 1'b0);
        check("accept_gap", accept_cyc - prev_accept_cyc, 21);

        convert(20'd1048575, 24'h048575, 1'b1, 6'b011111, 1'b0);
        convert(20'd1000000, 24'h000000, 1'b1, 6'b000001, 1'b0);
        convert(20'd42, 24'h000042, 1'b0, 6'b000011, 1'b0);

        // new value presented during SHIFT must be ignored
        convert(20'd314159, 24'h314159, 1'b0, 6'b111111, 1'b1);
        @(posedge clk);
        #1;
        check("poke_not_buffered", in_ready, 1'b1);
        check("out_valid_one_cycle", out_valid, 1'b0);

        // reset at shift 10 of a 777777 conversion
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 20'd777777;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_digits", digits, 24'h000000);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_digit_en", digit_en, 6'h3f);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_publish", seen, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_digits_after", digits, 24'h000000);
        prev_digits = '0;
        prev_ovf    = 1'b0;

        convert(20'd65535, 24'h065535, 1'b0, 6'b011111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
